// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one byte per frame
// with a single-cycle done or frame_err strobe.
module uart_rx #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int COUNT_CYCLES = CLK_FREQ / BAUD,
    parameter int HALF_CYCLES  = COUNT_CYCLES / 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] o_data_out,
    output logic       o_done,
    output logic       o_frame_err,
    output logic       o_busy
);
    localparam int CW = (COUNT_CYCLES > 1) ? $clog2(COUNT_CYCLES) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(COUNT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]    r_sync;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shreg;
    logic [7:0]    r_data;
    logic          r_done;
    logic          r_err;
    logic          w_rx_s;

    assign w_rx_s      = r_sync[1];
    assign o_data_out  = r_data;
    assign o_done      = r_done;
    assign o_frame_err = r_err;
    assign o_busy      = (r_state != S_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rx_s) r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == HALF_M1) begin
                        r_cnt <= '0;
                        // a start bit that is already high again at its midpoint is noise
                        if (!w_rx_s) begin
                            r_state <= S_DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == FULL_M1) begin
                        r_cnt   <= '0;
                        r_shreg <= {w_rx_s, r_shreg[7:1]};
                        if (r_idx == 3'd7) r_state <= S_STOP;
                        else               r_idx   <= r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == FULL_M1) begin
                        // leave at mid-stop so an immediately following start edge is caught
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (w_rx_s) begin
                            r_data <= r_shreg;
                            r_done <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frame stimulus for uart_rx, checked against a
// frame-level model of expected bytes, error counts and strobe timing.
module tb_uart_rx;
    localparam int BAUD     = 9600;
    localparam int C        = 16;
    localparam int H        = C / 2;
    localparam int CLK_FREQ = BAUD * C;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       done, ferr, busy;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx(rx),
        .o_data_out(data_out), .o_done(done), .o_frame_err(ferr), .o_busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] done_q[$];
    int         done_cyc[$];
    int         err_n = 0;
    logic       pd = 1'b0, pe = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // strobe monitor: records every event and checks strobe shape
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_q.push_back(data_out);
                done_cyc.push_back(cyc);
                chk("busy_at_done", 32'(busy), 0);
                chk("done_twice", 32'(pd), 0);
            end
            if (ferr) begin
                err_n++;
                chk("busy_at_err", 32'(busy), 0);
                chk("err_twice", 32'(pe), 0);
            end
            if (done || ferr) chk("done_err_excl", 32'(done & ferr), 0);
        end
        pd = done;
        pe = ferr;
    end

    // drives one frame from a negedge; the start bit may already have been low for pre cycles
    task automatic send(input logic [7:0] b, input logic stop, input int pre);
        rx = 1'b0;
        repeat (C - pre) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = stop;
        repeat (C) @(negedge clk);
        rx = 1'b1;
    endtask

    initial begin
        int k;
        logic [7:0] exp_b[3];
        logic [7:0] model_q[$];
        logic [7:0] last;
        logic [7:0] b;
        logic       good;
        int         exp_err;

        // reset
        rst = 1'b1; rx = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ferr", 32'(ferr), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // single frame A5 with busy onset and latency
        k = cyc;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_before", 32'(busy), 0);
        @(negedge clk);
        chk("busy_onset", 32'(busy), 1);
        send(8'hA5, 1'b1, 3);
        repeat (4) @(negedge clk);
        chk("a5_count", 32'(done_q.size()), 1);
        if (done_q.size() == 1) begin
            chk("a5_data", 32'(done_q[0]), 32'h A5);
            chk("a5_latency", 32'(done_cyc[0] - k), 32'(3 + H + 9 * C));
        end
        chk("a5_err", 32'(err_n), 0);
        done_q.delete(); done_cyc.delete();

        // back-to-back frames
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        for (int i = 0; i < 3; i++) send(exp_b[i], 1'b1, 0);
        repeat (4) @(negedge clk);
        chk("b2b_count", 32'(done_q.size()), 3);
        for (int i = 0; i < 3 && i < done_q.size(); i++) chk("b2b_data", 32'(done_q[i]), 32'(exp_b[i]));
        chk("b2b_err", 32'(err_n), 0);
        done_q.delete(); done_cyc.delete();

        // glitch on start bit
        rx = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_busy_up", 32'(busy), 1);
        @(negedge clk);
        rx = 1'b1;
        repeat (H - 2) @(negedge clk);
        chk("glitch_busy_hold", 32'(busy), 1);
        @(negedge clk);
        chk("glitch_busy_down", 32'(busy), 0);
        repeat (2 * C) @(negedge clk);
        chk("glitch_done", 32'(done_q.size()), 0);
        chk("glitch_err", 32'(err_n), 0);
        chk("glitch_data", 32'(data_out), 32'h3C);

        // framing error
        send(8'h5A, 1'b0, 0);
        repeat (3 * C) @(negedge clk);
        chk("ferr_count", 32'(err_n), 1);
        chk("ferr_done", 32'(done_q.size()), 0);
        chk("ferr_data", 32'(data_out), 32'h3C);
        err_n = 0;

        // randomized frames against the frame-level model
        last = 8'h3C;
        exp_err = 0;
        for (int n = 0; n < 10; n++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send(b, good, 0);
            if (good) begin
                model_q.push_back(b);
                last = b;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end else begin
                exp_err++;
                repeat (2 * C) @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
        chk("rand_count", 32'(done_q.size()), 32'(model_q.size()));
        for (int i = 0; i < model_q.size() && i < done_q.size(); i++) chk("rand_data", 32'(done_q[i]), 32'(model_q[i]));
        chk("rand_err", 32'(err_n), 32'(exp_err));
        chk("rand_last", 32'(data_out), 32'(last));
        done_q.delete(); done_cyc.delete(); err_n = 0;

        // reset during data bit 4 of C3, then a clean frame
        b = 8'hC3;
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (C) @(negedge clk);
        end
        rx = b[4];
        repeat (H) @(negedge clk);
        chk("mid_busy_pre", 32'(busy), 1);
        rst = 1'b1; rx = 1'b1;
        @(negedge clk);
        chk("mid_busy_rst", 32'(busy), 0);
        chk("mid_data_rst", 32'(data_out), 0);
        rst = 1'b0;
        repeat (2 * C) @(negedge clk);
        chk("mid_no_done", 32'(done_q.size()), 0);
        chk("mid_no_err", 32'(err_n), 0);
        send(8'h81, 1'b1, 0);
        repeat (4) @(negedge clk);
        chk("mid_next_count", 32'(done_q.size()), 1);
        chk("mid_next_data", 32'(data_out), 32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
